// File: rtl/vector_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_add_sequencer
// Description : Folded element-wise M31 vector adder. LANES modular adders
//               are reused over VECTOR_SIZE/LANES beats, with valid/ready
//               handshakes on both sides.
//               Optional macro VEC_ADD_SEQ_PERF_EN adds op_count/stall_count.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_add_sequencer #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16,
    parameter int LANES       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] vec1   [0:VECTOR_SIZE-1],
    input  logic [WORD_WIDTH-1:0] vec2   [0:VECTOR_SIZE-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] result [0:VECTOR_SIZE-1],
`ifdef VEC_ADD_SEQ_PERF_EN
    output logic [31:0]           op_count,
    output logic [31:0]           stall_count,
`endif
    output logic                  busy
);

    localparam int c_BEATS  = VECTOR_SIZE / LANES;
    localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_IDX_W  = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam logic [c_BEAT_W-1:0]   c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
    localparam logic [WORD_WIDTH:0]   c_MODULUS   = {1'b0, {WORD_WIDTH{1'b1}}};

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COMPUTE = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;

    generate
        if ((VECTOR_SIZE % LANES) != 0) begin : g_cfg_error
            $error("vector_add_sequencer: VECTOR_SIZE must be a multiple of LANES");
        end
    endgenerate

    // Single conditional subtraction: p + p maps to p, not 0.
    function automatic logic [WORD_WIDTH-1:0] addm(input logic [WORD_WIDTH-1:0] a,
                                                   input logic [WORD_WIDTH-1:0] b);
        logic [WORD_WIDTH:0] s;
        logic [WORD_WIDTH:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = (s >= c_MODULUS) ? (s - c_MODULUS) : s;
        return r[WORD_WIDTH-1:0];
    endfunction

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [WORD_WIDTH-1:0] r_op1    [0:VECTOR_SIZE-1];
    logic [WORD_WIDTH-1:0] r_op2    [0:VECTOR_SIZE-1];
    logic [WORD_WIDTH-1:0] r_result [0:VECTOR_SIZE-1];
    logic [c_IDX_W-1:0]    w_base;
    logic [c_IDX_W-1:0]    w_lane_idx [0:LANES-1];
    logic [WORD_WIDTH-1:0] w_lane_sum [0:LANES-1];

    assign w_base = c_IDX_W'(r_beat) * c_IDX_W'(LANES);

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            assign w_lane_idx[j] = w_base + c_IDX_W'(j);
            assign w_lane_sum[j] = addm(r_op1[w_lane_idx[j]], r_op2[w_lane_idx[j]]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (in_valid)               w_state_nxt = c_ST_COMPUTE;
            c_ST_COMPUTE: if (r_beat == c_LAST_BEAT)  w_state_nxt = c_ST_DONE;
            c_ST_DONE:    if (out_ready)              w_state_nxt = c_ST_IDLE;
            default:                                  w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                r_op1[i]    <= '0;
                r_op2[i]    <= '0;
                r_result[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_op1  <= vec1;
                        r_op2  <= vec2;
                        r_beat <= '0;
                    end
                end
                c_ST_COMPUTE: begin
                    for (int j = 0; j < LANES; j++) begin
                        r_result[w_lane_idx[j]] <= w_lane_sum[j];
                    end
                    r_beat <= (r_beat == c_LAST_BEAT) ? '0 : r_beat + c_BEAT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef VEC_ADD_SEQ_PERF_EN
    logic [31:0] r_op_count;
    logic [31:0] r_stall_count;

    // op_count wraps naturally; stall_count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count    <= '0;
            r_stall_count <= '0;
        end else if (r_state == c_ST_DONE) begin
            if (out_ready) begin
                r_op_count <= r_op_count + 32'd1;
            end else if (r_stall_count != 32'hFFFF_FFFF) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign op_count    = r_op_count;
    assign stall_count = r_stall_count;
`endif

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);
    assign busy      = (r_state != c_ST_IDLE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_vector_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_add_sequencer
// Description : Directed and random checks of vector_add_sequencer, including
//               LANES=8 and LANES=1 instances for latency sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_add_sequencer;

    localparam logic [30:0] c_PM1 = 31'h7FFF_FFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_valid8 = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, busy;
    logic        in_ready8, out_valid8, busy8;
    logic        in_ready1, out_valid1, busy1;
    logic [30:0] vec1    [0:15];
    logic [30:0] vec2    [0:15];
    logic [30:0] result  [0:15];
    logic [30:0] result8 [0:15];
    logic [30:0] result1 [0:15];
    logic [31:0] expv    [0:15];
`ifdef VEC_ADD_SEQ_PERF_EN
    logic [31:0] op_count, stall_count, op_count8, stall_count8, op_count1, stall_count1;
`endif
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    vector_add_sequencer #(.WORD_WIDTH(31), .VECTOR_SIZE(16), .LANES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .vec1(vec1), .vec2(vec2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
`ifdef VEC_ADD_SEQ_PERF_EN
        .op_count(op_count), .stall_count(stall_count),
`endif
        .busy(busy)
    );

    vector_add_sequencer #(.WORD_WIDTH(31), .VECTOR_SIZE(16), .LANES(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .vec1(vec1), .vec2(vec2), .out_valid(out_valid8), .out_ready(out_ready),
        .result(result8),
`ifdef VEC_ADD_SEQ_PERF_EN
        .op_count(op_count8), .stall_count(stall_count8),
`endif
        .busy(busy8)
    );

    vector_add_sequencer #(.WORD_WIDTH(31), .VECTOR_SIZE(16), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .vec1(vec1), .vec2(vec2), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1),
`ifdef VEC_ADD_SEQ_PERF_EN
        .op_count(op_count1), .stall_count(stall_count1),
`endif
        .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_addm(input logic [30:0] a, input logic [30:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s >= 64'h7FFF_FFFF) s = s - 64'h7FFF_FFFF;
        return 32'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_uniform(input logic [30:0] a, input logic [30:0] b, input logic [31:0] e);
        for (int i = 0; i < 16; i++) begin
            vec1[i] = a;
            vec2[i] = b;
            expv[i] = e;
        end
    endtask

    task automatic start_op();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Returns edges from handshake to out_valid and cycles seen with in_ready low.
    task automatic wait_done(output int lat, output int low);
        lat = 0;
        low = in_ready ? 0 : 1;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
            if (!in_ready) low++;
        end
        if (lat >= 50) chk("wait_done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic check_vec(input string tag);
        for (int i = 0; i < 16; i++) chk(tag, 32'(result[i]), expv[i]);
    endtask

    task automatic sweep(input int lanes, input int nvec);
        int lat;
        for (int n = 0; n < nvec; n++) begin
            for (int i = 0; i < 16; i++) begin
                vec1[i] = 31'($urandom_range(32'h7FFF_FFFE, 0));
                vec2[i] = 31'($urandom_range(32'h7FFF_FFFE, 0));
                expv[i] = ref_addm(vec1[i], vec2[i]);
            end
            if (lanes == 8) in_valid8 = 1'b1; else in_valid1 = 1'b1;
            step();
            in_valid8 = 1'b0;
            in_valid1 = 1'b0;
            lat = 0;
            while (!((lanes == 8) ? out_valid8 : out_valid1) && lat < 50) begin
                step();
                lat++;
            end
            chk((lanes == 8) ? "sweep8_latency" : "sweep1_latency", 32'(lat), 32'(16 / lanes));
            for (int i = 0; i < 16; i++)
                chk((lanes == 8) ? "sweep8_result" : "sweep1_result",
                    32'((lanes == 8) ? result8[i] : result1[i]), expv[i]);
            step();
        end
    endtask

    initial begin
        int lat, low;
        set_uniform(31'd0, 31'd0, 32'd0);
        step();
        do_reset();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result0", 32'(result[0]), 32'd0);
        chk("reset_result15", 32'(result[15]), 32'd0);

        // Basic op: result[i] = 100 + 2i
        for (int i = 0; i < 16; i++) begin
            vec1[i] = 31'(i);
            vec2[i] = 31'(100 + i);
            expv[i] = 32'(100 + 2 * i);
        end
        out_ready = 1'b1;
        start_op();
        chk("basic_busy", 32'(busy), 32'd1);
        wait_done(lat, low);
        chk("basic_latency", 32'(lat), 32'd4);
        chk("basic_in_ready_low", 32'(low), 32'd5);
        check_vec("basic_result");
        step();
        chk("basic_back_idle", 32'(in_ready), 32'd1);
        chk("basic_out_valid_drop", 32'(out_valid), 32'd0);

        // Wrap case; operands and in_valid changed while busy must be ignored
        set_uniform(c_PM1, 31'd5, 32'd4);
        start_op();
        set_uniform(31'd0, 31'd0, 32'd4);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_done(lat, low);
        check_vec("wrap_a_result");
        step();

        set_uniform(31'h4000_0000, 31'h3FFF_FFFF, 32'd0);
        start_op();
        wait_done(lat, low);
        check_vec("wrap_b_result");
        step();

        // Boundaries interleaved across lanes
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: begin vec1[i] = 31'd0;         vec2[i] = 31'd0;         expv[i] = 32'd0;          end
                1: begin vec1[i] = c_PM1;         vec2[i] = 31'd1;         expv[i] = 32'd0;          end
                2: begin vec1[i] = 31'h7FFF_FFFF; vec2[i] = 31'h7FFF_FFFF; expv[i] = 32'h7FFF_FFFF; end
                default: begin vec1[i] = c_PM1;   vec2[i] = 31'd0;         expv[i] = 32'h7FFF_FFFE; end
            endcase
        end
        start_op();
        wait_done(lat, low);
        check_vec("boundary_result");
        step();

        // Backpressure: 0x7FFFFFF0 + (0x20+i) wraps to 0x11+i
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vec1[i] = 31'h7FFF_FFF0;
            vec2[i] = 31'(32'h20 + i);
            expv[i] = 32'(32'h11 + i);
        end
        start_op();
        wait_done(lat, low);
        chk("bp_latency", 32'(lat), 32'd4);
        check_vec("bp_result_first");
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_hold_ready_valid", {30'd0, in_ready, out_valid}, 32'd1);
            check_vec("bp_result_stable");
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
`ifdef VEC_ADD_SEQ_PERF_EN
        chk("perf_stall_count", stall_count, 32'd10);
        chk("perf_op_count", op_count, 32'd1);
`endif

        // Reset on the 2nd COMPUTE edge aborts the op
        set_uniform(31'd1, 31'd2, 32'd3);
        start_op();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result_cleared", 32'(result[0]), 32'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        set_uniform(31'd7, 31'd7, 32'd14);
        start_op();
        wait_done(lat, low);
        chk("after_abort_latency", 32'(lat), 32'd4);
        check_vec("after_abort_result");
        step();

        // Random canonical vectors against reference model
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 16; i++) begin
                vec1[i] = 31'($urandom_range(32'h7FFF_FFFE, 0));
                vec2[i] = 31'($urandom_range(32'h7FFF_FFFE, 0));
                expv[i] = ref_addm(vec1[i], vec2[i]);
            end
            start_op();
            wait_done(lat, low);
            chk("rand_latency", 32'(lat), 32'd4);
            check_vec("rand_result");
            step();
        end

        sweep(8, 20);
        sweep(1, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
